shift_out_32_bit: RTL and testbench
===================================

Name: shift_out_32_bit

Overview:
Parallel-in, serial-out transmitter. It loads a 32-bit word (typically the Data_Out of a 32-bit enable register) and shifts it out MSB-first on a 1-bit line, one bit per enabled clock. It is the read/egress end of the register path. It provides a Busy/Done handshake toward the loader and a per-bit advance control (Shift_Enable) from the downstream consumer.

Parameters:
WIDTH, 32, word width in bits; must be >= 2
COUNT_W, 5, bit-counter width; must equal ceil(log2(WIDTH))

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Data_In  input  WIDTH  word to transmit; sampled only on an accepted load
Load  input  1  load request; accepted only in IDLE
Shift_Enable  input  1  consumer advance strobe; the current bit is consumed and the next bit presented only when high
Serial_Out  output  1  current bit, MSB of internal shift register
Serial_Valid  output  1  high while Serial_Out carries a word bit (SHIFT state)
Busy  output  1  high in SHIFT and DONE; loader must not expect Load to be accepted
Done  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- Reset (Reset=0, async): state=IDLE, shift_reg=0, count=0. Outputs: Serial_Out=0, Serial_Valid=0, Busy=0, Done=0. Reset mid-word aborts the word; Done is not issued.
- Registered state machine, states IDLE, SHIFT, DONE. Serial_Valid, Busy and Done decode from state only. Serial_Out = shift_reg[WIDTH-1].
- IDLE: on an edge with Load=1, shift_reg<=Data_In, count<=0, state<=SHIFT. Latency is 1 cycle: bit WIDTH-1 is on Serial_Out with Serial_Valid=1 the cycle after Load is sampled. With Load=0, state holds.
- SHIFT: on an edge with Shift_Enable=1:
  - if count==WIDTH-1: shift_reg<=0, count<=0, state<=DONE.
  - else: shift_reg<=shift_reg<<1 with zero fill, count<=count+1.
  - With Shift_Enable=0, everything holds and Serial_Out stays stable (stall).
- Bit k of the transmission (k=0..WIDTH-1) equals Data_In[WIDTH-1-k]. A receiver samples Serial_Out on edges where Serial_Valid && Shift_Enable.
- Minimum word time is 1 load cycle + WIDTH shift cycles + 1 DONE cycle. Back-to-back throughput is one word per WIDTH+2 cycles.
- DONE: Done=1 for exactly one cycle. Next state is IDLE unconditionally. Load in DONE is ignored, not queued.
- Load while Busy=1 is ignored, and Data_In changes are ignored. The in-flight word is never corrupted.
- Shift_Enable in IDLE or DONE has no effect.
- Load and Shift_Enable both high in IDLE: the load is accepted and the shift is not applied in the same cycle.
- Serial_Out=0 whenever Serial_Valid=0.
- count never exceeds WIDTH-1. There is no wrap-around path.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2, plus the default WIDTH.
- Single module. The shift register and counter live inline, with no sub-module.
- It instantiates cleanly downstream of register_32_bit: Data_In is tied to that register's Data_Out.

Test Plan:
- Reset: hold Reset=0 with Load=1 and Data_In=32'hFFFFFFFF -> all outputs 0 and state IDLE. After release, the next Load is accepted normally.
- Basic word: load 32'h8000_0001 with Shift_Enable=1 continuously -> Serial_Valid high 32 cycles, serial stream 1,0x30,1, Done pulses once on cycle 34 after Load, Busy low on cycle 35.
- Stall: load 32'hA5A5_A5A5 and toggle Shift_Enable 1,0,1,0... -> each bit held 2 cycles, reassembled word equals 32'hA5A5_A5A5, Done after 64 shift-phase cycles.
- Load while busy: load 32'h0000_00AC, then assert Load with Data_In=32'h32 at bits 5 and 31 and during DONE -> transmitted word is 32'hAC, and no second word starts until a Load sampled in IDLE.
- Reset mid-operation: load 32'hDEAD_BEEF, pulse Reset low after 10 bits -> immediate IDLE, Serial_Out=0, no Done. A following load of 32'h50 transmits correctly.
- Back-to-back: Load held high continuously with Data_In=32'hB then 32'hC -> words start exactly 34 cycles apart, each bit-exact, Done between them.

Source files
------------

// File: rtl/shift_out_32_bit_pkg.sv
// ----------------------------------------------------------------------------
// shift_out_32_bit_pkg
// Shared definitions for the 32-bit parallel-in / serial-out transmitter:
//   - default word width and bit-counter width
//   - state encoding of the transmit controller (IDLE, SHIFT, DONE)
// ----------------------------------------------------------------------------
package shift_out_32_bit_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_COUNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_out_32_bit.sv
// ----------------------------------------------------------------------------
// shift_out_32_bit
// Parallel-in, serial-out transmitter. A word is captured on an accepted Load
// and presented MSB-first on Serial_Out. One bit is consumed on every clock
// edge that sees Shift_Enable high while in SHIFT. A single-cycle Done
// follows the last consumed bit.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous, active-low reset
//   Data_In      in   [WIDTH]  word to send, sampled only on an accepted load
//   Load         in   load request, honoured only in IDLE
//   Shift_Enable in   consumer strobe: consume current bit, present next
//   Serial_Out   out  current bit (MSB of the shift register)
//   Serial_Valid out  high while a word bit is presented (SHIFT)
//   Busy         out  high in SHIFT and DONE
//   Done         out  one-cycle pulse after the last bit is consumed
// ----------------------------------------------------------------------------
module shift_out_32_bit
    import shift_out_32_bit_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Load,
    input  logic             Shift_Enable,
    output logic             Serial_Out,
    output logic             Serial_Valid,
    output logic             Busy,
    output logic             Done
);

    localparam logic [COUNT_W-1:0] LAST_BIT  = COUNT_W'(WIDTH - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   shift_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_s;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;

    // Next-state, next shift-register and next counter values.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                // Shift_Enable is deliberately ignored here, even together
                // with Load: the loaded MSB must be presented for a full cycle.
                if (Load) begin
                    state_s = ST_SHIFT;
                    shift_s = Data_In;
                    count_s = {COUNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (Shift_Enable) begin
                    if (count_r == LAST_BIT) begin
                        // Clearing the register keeps Serial_Out low outside SHIFT.
                        state_s = ST_DONE;
                        shift_s = {WIDTH{1'b0}};
                        count_s = {COUNT_W{1'b0}};
                    end else begin
                        shift_s = {shift_r[WIDTH-2:0], 1'b0};
                        count_s = count_r + COUNT_ONE;
                    end
                end else begin
                    // Stall: hold the presented bit.
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Load here is dropped, not queued.
                state_s = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean IDLE.
                state_s = ST_IDLE;
                shift_s = {WIDTH{1'b0}};
                count_s = {COUNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and status registers; status flags are decoded from
    // the next state so they line up exactly with the registered state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            shift_r <= {WIDTH{1'b0}};
            count_r <= {COUNT_W{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            count_r <= count_s;
            valid_r <= (state_s == ST_SHIFT);
            busy_r  <= (state_s == ST_SHIFT) || (state_s == ST_DONE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign Serial_Out   = shift_r[WIDTH-1];
    assign Serial_Valid = valid_r;
    assign Busy         = busy_r;
    assign Done         = done_r;

endmodule

// File: tb/tb_shift_out_32_bit.sv
// ----------------------------------------------------------------------------
// tb_shift_out_32_bit
// Self-checking bench for shift_out_32_bit. Expected words come from the data
// that was loaded; expected timing comes from counting consumed bits.
// ----------------------------------------------------------------------------
module tb_shift_out_32_bit;

    logic        Clock;
    logic        Reset;
    logic [31:0] Data_In;
    logic        Load;
    logic        Shift_Enable;
    logic        Serial_Out;
    logic        Serial_Valid;
    logic        Busy;
    logic        Done;

    int checks;
    int errors;

    shift_out_32_bit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Data_In     (Data_In),
        .Load        (Load),
        .Shift_Enable(Shift_Enable),
        .Serial_Out  (Serial_Out),
        .Serial_Valid(Serial_Valid),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Sends one word and acts as the receiver. mode: 0 = always enabled,
    // 1 = enable 0,1,0,1... during SHIFT, 2 = random. poke asserts Load with
    // 32'h32 while bits 5 and 31 are presented and during DONE.
    // Observation n is clock cycle n+1, the load cycle being cycle 1.
    task automatic tx_word(input logic [31:0] d, input int mode, input bit poke,
                           output logic [31:0] got, output int nbits,
                           output int done_at, output int done_cnt,
                           output int end_at, output int last_n, output int bad);
        logic en;
        logic prev_en;
        logic prev_valid;
        logic prev_bit;
        got = 32'h0; nbits = 0; done_at = 0; done_cnt = 0;
        end_at = 0; last_n = 0; bad = 0;
        @(negedge Clock);
        Load = 1'b1; Data_In = d; Shift_Enable = 1'b1;
        prev_en = 1'b1; prev_valid = 1'b0; prev_bit = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (!Serial_Valid && Serial_Out !== 1'b0) bad++;
            if (Serial_Valid && prev_valid && !prev_en && Serial_Out !== prev_bit) bad++;
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = n + 1;
            end
            if (Busy !== 1'b1) begin
                end_at = n + 1;
                break;
            end
            case (mode)
                0:       en = 1'b1;
                1:       en = (n % 2 == 0);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            Load    = poke && ((Serial_Valid && (nbits == 5 || nbits == 31)) || Done);
            Data_In = poke ? 32'h32 : $urandom;
            if (Serial_Valid && en) begin
                got = {got[30:0], Serial_Out};
                nbits++;
                if (nbits == 32) last_n = n;
            end
            Shift_Enable = en;
            prev_en = en; prev_valid = Serial_Valid; prev_bit = Serial_Out;
        end
        Load = 1'b0; Shift_Enable = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Load = 1'b1; Data_In = 32'hFFFF_FFFF; Shift_Enable = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++; if (Serial_Out !== 1'b0)   begin errors++; $display("FAIL reset_serial_out got=%b exp=0", Serial_Out); end
        checks++; if (Serial_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", Serial_Valid); end
        checks++; if (Busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0)         begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
        Reset = 1'b1; Load = 1'b0; Shift_Enable = 1'b0;
        @(negedge Clock);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_basic();
        logic [31:0] got; int nb, da, dc, ea, ln, bad;
        tx_word(32'h8000_0001, 0, 1'b0, got, nb, da, dc, ea, ln, bad);
        checks++; if (got !== 32'h8000_0001) begin errors++; $display("FAIL basic_word got=%h exp=80000001", got); end
        checks++; if (nb != 32)  begin errors++; $display("FAIL basic_nbits got=%0d exp=32", nb); end
        checks++; if (da != 34)  begin errors++; $display("FAIL basic_done_cycle got=%0d exp=34", da); end
        checks++; if (dc != 1)   begin errors++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
        checks++; if (ea != 35)  begin errors++; $display("FAIL basic_busy_low got=%0d exp=35", ea); end
        checks++; if (bad != 0)  begin errors++; $display("FAIL basic_invariants got=%0d exp=0", bad); end
    endtask

    task automatic test_stall();
        logic [31:0] got; int nb, da, dc, ea, ln, bad;
        tx_word(32'hA5A5_A5A5, 1, 1'b0, got, nb, da, dc, ea, ln, bad);
        checks++; if (got !== 32'hA5A5_A5A5) begin errors++; $display("FAIL stall_word got=%h exp=a5a5a5a5", got); end
        checks++; if (ln != 64)  begin errors++; $display("FAIL stall_last_bit got=%0d exp=64", ln); end
        checks++; if (da != 66)  begin errors++; $display("FAIL stall_done_cycle got=%0d exp=66", da); end
        checks++; if (dc != 1)   begin errors++; $display("FAIL stall_done_count got=%0d exp=1", dc); end
        checks++; if (bad != 0)  begin errors++; $display("FAIL stall_invariants got=%0d exp=0", bad); end
    endtask

    task automatic test_load_busy();
        logic [31:0] got; int nb, da, dc, ea, ln, bad; int extra;
        tx_word(32'h0000_00AC, 0, 1'b1, got, nb, da, dc, ea, ln, bad);
        checks++; if (got !== 32'h0000_00AC) begin errors++; $display("FAIL busy_word got=%h exp=000000ac", got); end
        checks++; if (da != 34)  begin errors++; $display("FAIL busy_done_cycle got=%0d exp=34", da); end
        checks++; if (dc != 1)   begin errors++; $display("FAIL busy_done_count got=%0d exp=1", dc); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (Serial_Valid !== 1'b0 || Busy !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_no_second_word got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] word; logic [31:0] got; int nb, da, dc, ea, ln, bad; int stray;
        word = 32'hDEAD_BEEF;
        @(negedge Clock);
        Load = 1'b1; Data_In = word; Shift_Enable = 1'b1;
        @(negedge Clock);
        Load = 1'b0; Data_In = 32'h0;
        repeat (10) @(negedge Clock);
        checks++; if (Serial_Valid !== 1'b1 || Serial_Out !== word[21]) begin
            errors++; $display("FAIL mid_bit10 got=%b/%b exp=1/%b", Serial_Valid, Serial_Out, word[21]);
        end
        #2 Reset = 1'b0;
        #1;
        checks++; if ({Serial_Out, Serial_Valid, Busy, Done} !== 4'b0000) begin
            errors++; $display("FAIL mid_async_clear got=%b exp=0000", {Serial_Out, Serial_Valid, Busy, Done});
        end
        @(negedge Clock);
        Reset = 1'b1; Shift_Enable = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Done !== 1'b0 || Busy !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", stray); end
        tx_word(32'h0000_0050, 0, 1'b0, got, nb, da, dc, ea, ln, bad);
        checks++; if (got !== 32'h0000_0050) begin errors++; $display("FAIL mid_next_word got=%h exp=00000050", got); end
        checks++; if (da != 34) begin errors++; $display("FAIL mid_next_done got=%0d exp=34", da); end
    endtask

    task automatic test_back_to_back();
        int starts[$]; int dones[$]; logic [31:0] w[2]; int widx; logic pv; bit drained;
        w[0] = 32'h0; w[1] = 32'h0; widx = -1; pv = 1'b0;
        @(negedge Clock);
        Load = 1'b1; Data_In = 32'hB; Shift_Enable = 1'b1;
        for (int n = 1; n <= 75; n++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (Serial_Valid && !pv) begin starts.push_back(n); widx++; end
            if (Done === 1'b1) dones.push_back(n);
            if (Serial_Valid && widx >= 0 && widx < 2) w[widx] = {w[widx][30:0], Serial_Out};
            if (widx >= 0) Data_In = 32'hC;
            pv = Serial_Valid;
        end
        Load = 1'b0;
        checks++;
        if (starts.size() < 2) begin
            errors++; $display("FAIL b2b_starts got=%0d exp>=2", starts.size());
        end else begin
            if (starts[1] - starts[0] != 34) begin errors++; $display("FAIL b2b_spacing got=%0d exp=34", starts[1] - starts[0]); end
            checks++; if (w[0] !== 32'hB) begin errors++; $display("FAIL b2b_word0 got=%h exp=0000000b", w[0]); end
            checks++; if (w[1] !== 32'hC) begin errors++; $display("FAIL b2b_word1 got=%h exp=0000000c", w[1]); end
            checks++;
            if (dones.size() < 1 || dones[0] <= starts[0] || dones[0] >= starts[1]) begin
                errors++; $display("FAIL b2b_done_between got=%0d exp=between %0d and %0d",
                                   (dones.size() > 0) ? dones[0] : -1, starts[0], starts[1]);
            end
        end
        drained = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (Busy === 1'b0) begin drained = 1'b1; break; end
        end
        checks++; if (!drained) begin errors++; $display("FAIL b2b_drain got=busy exp=idle"); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic [31:0] got; int nb, da, dc, ea, ln, bad;
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            tx_word(d, 2, 1'b0, got, nb, da, dc, ea, ln, bad);
            checks++; if (got !== d) begin errors++; $display("FAIL rand_word[%0d] got=%h exp=%h", k, got, d); end
            checks++; if (da != ln + 2) begin errors++; $display("FAIL rand_done[%0d] got=%0d exp=%0d", k, da, ln + 2); end
            checks++; if (ea != da + 1 || dc != 1) begin
                errors++; $display("FAIL rand_end[%0d] got=%0d/%0d exp=%0d/1", k, ea, dc, da + 1);
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_invariants[%0d] got=%0d exp=0", k, bad); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        Reset = 1'b0; Load = 1'b0; Data_In = 32'h0; Shift_Enable = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_load_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
